// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: holds the fetched instruction in an IR
// and walks it through FETCH/DECODE/EXEC/MEM/WB with bounded memory waits.
module mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] instr_i,
   input  logic        imem_ready_i,
   input  logic        dmem_ready_i,
   input  logic        br_less_i,
   input  logic        br_equal_i,
   output logic        imem_req_o,
   output logic        ir_wren_o,
   output logic        dmem_req_o,
   output logic        mem_wren_o,
   output logic        pc_wren_o,
   output logic        br_sel_o,
   output logic        br_unsigned_o,
   output logic        rd_wren_o,
   output logic        op_a_sel_o,
   output logic        op_b_sel_o,
   output logic [3:0]  alu_op_o,
   output logic [2:0]  width_o,
   output logic [1:0]  wb_sel_o,
   output logic [2:0]  state_o,
   output logic        retire_o,
   output logic        trap_o
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   logic [2:0]  state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  cnt_inc;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   assign opcode = ir_q[6:0];
   assign f3     = ir_q[14:12];
   assign f7     = ir_q[31:25];

   // Register and immediate fields are consumed by the datapath, not here.
   logic unused_ir;
   assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

   function automatic logic [3:0] alu_from_f3(input logic [2:0] fn3, input logic alt);
      case (fn3)
         3'b000:  alu_from_f3 = alt ? 4'b0001 : 4'b0000;
         3'b001:  alu_from_f3 = 4'b0111;
         3'b010:  alu_from_f3 = 4'b0010;
         3'b011:  alu_from_f3 = 4'b0011;
         3'b100:  alu_from_f3 = 4'b0100;
         3'b101:  alu_from_f3 = alt ? 4'b1001 : 4'b1000;
         3'b110:  alu_from_f3 = 4'b0101;
         default: alu_from_f3 = 4'b0110;
      endcase
   endfunction

   logic       legal, is_load, is_store, is_branch, is_jump, taken, br_uns;
   logic       op_a_dec, op_b_dec;
   logic [3:0] alu_dec;
   logic [2:0] width_dec;
   logic [1:0] wb_dec;

   always_comb begin
      legal     = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      br_uns    = 1'b0;
      op_a_dec  = 1'b0;
      op_b_dec  = 1'b0;
      alu_dec   = 4'b0000;
      width_dec = 3'b000;
      wb_dec    = 2'b00;
      case (opcode)
         OP_R: begin
            legal   = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            alu_dec = alu_from_f3(f3, f7[5]);
            wb_dec  = 2'b01;
         end
         OP_I: begin
            if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            else                   legal = 1'b1;
            alu_dec  = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
            op_b_dec = 1'b1;
            wb_dec   = 2'b01;
         end
         OP_LOAD: begin
            is_load  = 1'b1;
            op_b_dec = 1'b1;
            case (f3)
               3'b000:  begin legal = 1'b1; width_dec = 3'b000; end
               3'b001:  begin legal = 1'b1; width_dec = 3'b010; end
               3'b010:  begin legal = 1'b1; width_dec = 3'b111; end
               3'b100:  begin legal = 1'b1; width_dec = 3'b100; end
               3'b101:  begin legal = 1'b1; width_dec = 3'b110; end
               default: legal = 1'b0;
            endcase
         end
         OP_STORE: begin
            is_store = 1'b1;
            op_b_dec = 1'b1;
            case (f3)
               3'b000:  begin legal = 1'b1; width_dec = 3'b000; end
               3'b001:  begin legal = 1'b1; width_dec = 3'b001; end
               3'b010:  begin legal = 1'b1; width_dec = 3'b111; end
               default: legal = 1'b0;
            endcase
         end
         OP_BRANCH: begin
            is_branch = 1'b1;
            legal     = (f3 != 3'b010) && (f3 != 3'b011);
            br_uns    = (f3 == 3'b110) || (f3 == 3'b111);
            op_a_dec  = 1'b1;
            op_b_dec  = 1'b1;
         end
         OP_LUI: begin
            legal    = 1'b1;
            alu_dec  = 4'b1111;
            op_b_dec = 1'b1;
            wb_dec   = 2'b01;
         end
         OP_AUIPC: begin
            legal    = 1'b1;
            op_a_dec = 1'b1;
            op_b_dec = 1'b1;
            wb_dec   = 2'b01;
         end
         OP_JAL: begin
            legal    = 1'b1;
            is_jump  = 1'b1;
            op_a_dec = 1'b1;
            op_b_dec = 1'b1;
            wb_dec   = 2'b10;
         end
         OP_JALR: begin
            legal    = (f3 == 3'b000);
            is_jump  = 1'b1;
            op_b_dec = 1'b1;
            wb_dec   = 2'b10;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      case (f3)
         3'b000:          taken = br_equal_i;
         3'b001:          taken = !br_equal_i;
         3'b100, 3'b110:  taken = br_less_i;
         3'b101, 3'b111:  taken = !br_less_i;
         default:         taken = 1'b0;
      endcase
   end

   assign cnt_inc = cnt_q + 8'd1;

   logic imem_req, ir_wren, dmem_req, mem_wren, pc_wren, br_sel, rd_wren, retire;
   logic fields_en;

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      cnt_d    = cnt_q;
      imem_req = 1'b0;
      ir_wren  = 1'b0;
      dmem_req = 1'b0;
      mem_wren = 1'b0;
      pc_wren  = 1'b0;
      br_sel   = 1'b0;
      rd_wren  = 1'b0;
      retire   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready_i) begin
               ir_wren = 1'b1;
               ir_d    = instr_i;
               cnt_d   = 8'd0;
               state_d = S_DECODE;
            end else if (cnt_inc == TIMEOUT) begin
               cnt_d   = 8'd0;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DECODE: begin
            cnt_d   = 8'd0;
            state_d = legal ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            if (is_branch) begin
               pc_wren = 1'b1;
               br_sel  = taken;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            mem_wren = is_store;
            // A ready on the timeout cycle still completes the access.
            if (dmem_ready_i) begin
               cnt_d = 8'd0;
               if (is_store) begin
                  pc_wren = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (cnt_inc == TIMEOUT) begin
               cnt_d   = 8'd0;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WB: begin
            rd_wren = 1'b1;
            pc_wren = 1'b1;
            br_sel  = is_jump;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_FETCH;
         ir_q    <= 32'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Everything is forced low while reset is held, so no strobe leaks mid-access.
   assign fields_en     = rst_ni && ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));
   assign imem_req_o    = rst_ni & imem_req;
   assign ir_wren_o     = rst_ni & ir_wren;
   assign dmem_req_o    = rst_ni & dmem_req;
   assign mem_wren_o    = rst_ni & mem_wren;
   assign pc_wren_o     = rst_ni & pc_wren;
   assign br_sel_o      = rst_ni & br_sel;
   assign rd_wren_o     = rst_ni & rd_wren;
   assign retire_o      = rst_ni & retire;
   assign br_unsigned_o = fields_en & br_uns;
   assign op_a_sel_o    = fields_en & op_a_dec;
   assign op_b_sel_o    = fields_en & op_b_dec;
   assign alu_op_o      = fields_en ? alu_dec : 4'b0000;
   assign width_o       = fields_en ? width_dec : 3'b000;
   assign wb_sel_o      = fields_en ? wb_dec : 2'b00;
   assign state_o       = rst_ni ? state_q : S_FETCH;
   assign trap_o        = rst_ni && (state_q == S_TRAP);

endmodule
